// File: rtl/game_phase_sequencer.sv
// Round sequencer: start screen, character select, 3-2-1 countdown, FIGHT banner,
// battle and KO. Phases are timed in video frames. The one-hot phase flags drive the
// overlay renderers directly, and game_active gates player control.
module game_phase_sequencer #(
  parameter int unsigned COUNT_FRAMES = 60,
  parameter int unsigned FIGHT_FRAMES = 60,
  parameter int unsigned KO_FRAMES    = 180
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       start_btn,
  input  logic       confirm_btn,
  input  logic       p1_dead,
  input  logic       p2_dead,
  output logic       startscreen,
  output logic       characterselect,
  output logic       countdown3,
  output logic       countdown2,
  output logic       countdown1,
  output logic       fight,
  output logic       ko,
  output logic       game_active,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {
    StStart,
    StSelect,
    StCd3,
    StCd2,
    StCd1,
    StFight,
    StBattle,
    StKo
  } state_e;

  localparam logic [7:0] CountLast = 8'(COUNT_FRAMES - 1);
  localparam logic [7:0] FightLast = 8'(FIGHT_FRAMES - 1);
  localparam logic [7:0] KoLast    = 8'(KO_FRAMES - 1);

  state_e     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic [1:0] winner_q, winner_d;
  logic       start_q, confirm_q;

  logic frame_tick;
  logic start_press, confirm_press;
  logic any_dead;
  logic timed;
  logic [7:0] last_count;

  assign frame_tick    = (DrawX == 10'd0) && (DrawY == 10'd0);
  // Edge registers come out of reset high so a key held through reset is not a press.
  assign start_press   = start_btn & ~start_q;
  assign confirm_press = confirm_btn & ~confirm_q;
  assign any_dead      = p1_dead | p2_dead;

  // State, frame counter, winner and button history registers.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q   <= StStart;
      count_q   <= 8'd0;
      winner_q  <= 2'b00;
      start_q   <= 1'b1;
      confirm_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      winner_q  <= winner_d;
      start_q   <= start_btn;
      confirm_q <= confirm_btn;
    end
  end

  // Next state, winner latch and frame counter.
  always_comb begin
    state_d    = state_q;
    winner_d   = winner_q;
    count_d    = count_q;
    timed      = 1'b0;
    last_count = CountLast;

    unique case (state_q)
      StStart: begin
        if (start_press) state_d = StSelect;
      end
      StSelect: begin
        if (confirm_press) begin
          state_d  = StCd3;
          winner_d = 2'b00;
        end
      end
      StCd3: begin
        timed = 1'b1;
        if (frame_tick && count_q == CountLast) state_d = StCd2;
      end
      StCd2: begin
        timed = 1'b1;
        if (frame_tick && count_q == CountLast) state_d = StCd1;
      end
      StCd1: begin
        timed = 1'b1;
        if (frame_tick && count_q == CountLast) state_d = StFight;
      end
      StFight: begin
        timed      = 1'b1;
        last_count = FightLast;
        // A death takes priority over the banner timing out.
        if (any_dead) begin
          state_d  = StKo;
          winner_d = {p1_dead, p2_dead};
        end else if (frame_tick && count_q == FightLast) begin
          state_d = StBattle;
        end
      end
      StBattle: begin
        if (any_dead) begin
          state_d  = StKo;
          winner_d = {p1_dead, p2_dead};
        end
      end
      StKo: begin
        timed      = 1'b1;
        last_count = KoLast;
        if (frame_tick && count_q == KoLast) state_d = StStart;
      end
      default: state_d = StStart;
    endcase

    if (state_d != state_q) begin
      count_d = 8'd0;
    end else if (timed && frame_tick && count_q != last_count) begin
      count_d = count_q + 8'd1;
    end
  end

  // Phase flags are a pure decode of the current state.
  always_comb begin
    startscreen     = 1'b0;
    characterselect = 1'b0;
    countdown3      = 1'b0;
    countdown2      = 1'b0;
    countdown1      = 1'b0;
    fight           = 1'b0;
    ko              = 1'b0;
    game_active     = 1'b0;
    unique case (state_q)
      StStart:  startscreen     = 1'b1;
      StSelect: characterselect = 1'b1;
      StCd3:    countdown3      = 1'b1;
      StCd2:    countdown2      = 1'b1;
      StCd1:    countdown1      = 1'b1;
      StFight: begin
        fight       = 1'b1;
        game_active = 1'b1;
      end
      StBattle: game_active     = 1'b1;
      StKo:     ko              = 1'b1;
      default:  startscreen     = 1'b0;
    endcase
  end

  assign winner = winner_q;

endmodule

// File: tb/tb_game_phase_sequencer.sv
// Bench for game_phase_sequencer with short frame timings. Each step drives one cycle of
// inputs, queues the outputs expected after that edge, and checks them just after the edge.
module tb_game_phase_sequencer;

  localparam logic [6:0] FS   = 7'b1000000;
  localparam logic [6:0] FSEL = 7'b0100000;
  localparam logic [6:0] F3   = 7'b0010000;
  localparam logic [6:0] F2   = 7'b0001000;
  localparam logic [6:0] F1   = 7'b0000100;
  localparam logic [6:0] FF   = 7'b0000010;
  localparam logic [6:0] FK   = 7'b0000001;
  localparam logic [6:0] FB   = 7'b0000000;

  logic       vga_clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] DrawX = 10'd5;
  logic [9:0] DrawY = 10'd5;
  logic       start_btn = 1'b0;
  logic       confirm_btn = 1'b0;
  logic       p1_dead = 1'b0;
  logic       p2_dead = 1'b0;
  logic       startscreen, characterselect, countdown3, countdown2, countdown1;
  logic       fight, ko, game_active;
  logic [1:0] winner;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [6:0] flags;
    logic       act;
    logic [1:0] win;
  } exp_t;

  typedef struct {
    logic rst, st, cf, d1, d2, tk;
    exp_t exp;
  } vec_t;

  exp_t   sb[$];
  vec_t   vecs[$];

  game_phase_sequencer #(
    .COUNT_FRAMES(2),
    .FIGHT_FRAMES(1),
    .KO_FRAMES   (3)
  ) dut (
    .vga_clk        (vga_clk),
    .reset          (reset),
    .DrawX          (DrawX),
    .DrawY          (DrawY),
    .start_btn      (start_btn),
    .confirm_btn    (confirm_btn),
    .p1_dead        (p1_dead),
    .p2_dead        (p2_dead),
    .startscreen    (startscreen),
    .characterselect(characterselect),
    .countdown3     (countdown3),
    .countdown2     (countdown2),
    .countdown1     (countdown1),
    .fight          (fight),
    .ko             (ko),
    .game_active    (game_active),
    .winner         (winner)
  );

  always #5 vga_clk = ~vga_clk;

  function automatic vec_t mk(input logic rst, st, cf, d1, d2, tk,
                              input logic [6:0] f, input logic a, input logic [1:0] w);
    vec_t v;
    v.rst = rst; v.st = st; v.cf = cf; v.d1 = d1; v.d2 = d2; v.tk = tk;
    v.exp = '{flags: f, act: a, win: w};
    return v;
  endfunction

  task automatic step(input vec_t v, input int id);
    exp_t got, want;
    @(negedge vga_clk);
    reset       = v.rst;
    start_btn   = v.st;
    confirm_btn = v.cf;
    p1_dead     = v.d1;
    p2_dead     = v.d2;
    // Non-tick cycles sometimes zero one coordinate so only both-zero counts as a frame.
    DrawX       = v.tk ? 10'd0 : 10'(id % 3);
    DrawY       = v.tk ? 10'd0 : 10'(1 + id % 2);
    sb.push_back(v.exp);
    @(posedge vga_clk);
    #1;
    got  = '{flags: {startscreen, characterselect, countdown3, countdown2, countdown1, fight, ko},
             act: game_active, win: winner};
    want = sb.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL step%0d: got flags=%b active=%b winner=%b, want flags=%b active=%b winner=%b",
               id, got.flags, got.act, got.win, want.flags, want.act, want.win);
    end
  endtask

  initial begin
    // Start key held through reset and afterwards must not count as a press.
    step(mk(1, 1, 0, 0, 0, 0, FS, 0, 2'b00), 1000);
    step(mk(1, 1, 0, 0, 0, 1, FS, 0, 2'b00), 1001);
    for (int i = 0; i < 10; i++) step(mk(0, 1, 0, 0, 0, i % 4 == 0, FS, 0, 2'b00), 1010 + i);
    step(mk(0, 0, 0, 0, 0, 0, FS, 0, 2'b00), 1020);
    step(mk(0, 1, 0, 0, 0, 0, FSEL, 0, 2'b00), 1021);
    // Holding start across five frames stays in select.
    for (int i = 0; i < 10; i++) step(mk(0, 1, 0, 0, 0, i % 2 == 0, FSEL, 0, 2'b00), 1030 + i);

    // Full round walk from a fresh reset.
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, FS,   0, 2'b00));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, FS,   0, 2'b00));
    vecs.push_back(mk(0, 1, 0, 1, 1, 0, FSEL, 0, 2'b00)); // deaths ignored in start
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, FSEL, 0, 2'b00));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, FSEL, 0, 2'b00));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, F3,   0, 2'b00));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, F3,   0, 2'b00));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, F3,   0, 2'b00));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, F2,   0, 2'b00));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, F2,   0, 2'b00)); // buttons ignored
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, F2,   0, 2'b00));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, F1,   0, 2'b00));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, F1,   0, 2'b00)); // death ignored in countdown
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, F1,   0, 2'b00));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, FF,   1, 2'b00));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, FB,   1, 2'b00));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, FB,   1, 2'b00));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, FK,   0, 2'b01));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, FK,   0, 2'b01));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, FK,   0, 2'b01));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, FK,   0, 2'b01));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, FS,   0, 2'b01));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, FSEL, 0, 2'b01));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, F3,   0, 2'b00)); // winner cleared entering CD3
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, F3,   0, 2'b00));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, F2,   0, 2'b00));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, F2,   0, 2'b00));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, F1,   0, 2'b00));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, F1,   0, 2'b00));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, FF,   1, 2'b00));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, FK,   0, 2'b11)); // double KO beats timer expiry
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, FS,   0, 2'b00)); // reset clears winner
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, FS,   0, 2'b00));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, FSEL, 0, 2'b00));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, F3,   0, 2'b00));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, F3,   0, 2'b00));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, F2,   0, 2'b00));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, F2,   0, 2'b00));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, FS,   0, 2'b00)); // reset mid-CD2
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, FS,   0, 2'b00));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, FS,   0, 2'b00));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, FSEL, 0, 2'b00));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, F3,   0, 2'b00));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, F3,   0, 2'b00)); // counter restarted from 0
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, F2,   0, 2'b00));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, F2,   0, 2'b00));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, F1,   0, 2'b00));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, F1,   0, 2'b00));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, FF,   1, 2'b00));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, FK,   0, 2'b10)); // P2 wins from the banner

    foreach (vecs[i]) step(vecs[i], i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
